rgb_expand: RTL and testbench
=============================

# rgb_expand

Pixel-rate expander for the marker-detect path: the inverse end of the per-channel colour compressor. Accepts the 3-bit thresholded code stream (bit0 red, bit1 green, bit2 blue) over a valid/ready handshake. Maps each bit to a programmable per-channel low/high level and emits full RGB pixels through a 2-entry output buffer. Tags the last pixel of each line. Used to render the compressed stream back to the display pipeline and to drive debug overlays.

## Interface

**Parameters**
- `COLOUR_DEPTH`, default 8: bits per colour channel.
- `LINE_WIDTH`, default 640: pixels per line; sets the `eol_out` position.
- `LOW_DEFAULT`, default 0: reset value of every channel's low level.
- `HIGH_DEFAULT`, default `2**COLOUR_DEPTH-1`: reset value of every channel's high level.

**Ports** (one clock; reset is synchronous and active-high)
- `clk_in`, in, 1: clock; all state changes on its rising edge.
- `rst_in`, in, 1: synchronous active-high reset.
- `code_valid_in`, in, 1: `code_in` is valid this cycle.
- `code_in`, in, 3: compressed code; bit0 red, bit1 green, bit2 blue.
- `code_ready_out`, out, 1: the block can accept a code this cycle.
- `level_wr_in`, in, 1: write strobe for the level registers.
- `level_chan_in`, in, 2: selects the channel; 0 red, 1 green, 2 blue, 3 ignored (no write).
- `level_hi_in`, in, 1: 1 writes the high level, 0 writes the low level.
- `level_data_in`, in, `COLOUR_DEPTH`: level value to write.
- `rgb_valid_out`, out, 1: `rgb_out` and `eol_out` are valid.
- `rgb_ready_in`, in, 1: downstream accepts the pixel this cycle.
- `rgb_out`, out, `3*COLOUR_DEPTH`: red in `[CD-1:0]`, green in `[2CD-1:CD]`, blue in `[3CD-1:2CD]`.
- `eol_out`, out, 1: the current output pixel is column `LINE_WIDTH-1`.

## Operation

**Handshakes**
- Accept occurs when `code_valid_in && code_ready_out` at a clock edge.
- Pop occurs when `rgb_valid_out && rgb_ready_in` at a clock edge.

**Expansion**
- Each channel takes its high level if its code bit is 1, otherwise its low level.
- Expansion is computed at accept time from the level registers' current (pre-edge) values.
- The expanded pixel is stored in the buffer.

**Level registers**
- Six `COLOUR_DEPTH`-bit registers: low and high for each channel.
- A write is applied at the edge where `level_wr_in` is high.
- A write and an accept at the same edge: the accepted code uses the old level.
- No ordering check between levels; high < low is legal and simply inverts the channel.

**Column counter**
- Width is `$clog2(LINE_WIDTH)`; reset value 0.
- Increments on each accept and wraps from `LINE_WIDTH-1` to 0.
- The eol flag is stored with the pixel: 1 when the counter equals `LINE_WIDTH-1` at accept.

**Output buffer**
- 2-entry FIFO with occupancy `count` in 0..2.
- `code_ready_out = (count != 2)`, decoded from registered state only; there is no combinational path from `rgb_ready_in`.
- `rgb_valid_out = (count != 0)`.
- `rgb_out` and `eol_out` always show the head entry.
- Accept with count 0: the pixel becomes the head; count becomes 1.
- Accept and pop together with count 1: the new pixel becomes the head; count stays 1.
- Accept without pop with count 1: the pixel is stored as the second entry; count becomes 2.
- Pop with count 2: the second entry moves to the head; count becomes 1.
- Stall (valid && !ready): `rgb_out` and `eol_out` hold bit-stable. Nothing is dropped or duplicated.

**Reset** (`rst_in` high at an edge)
- count = 0, column = 0, all levels return to their defaults.
- Any accept or level write in the same cycle is discarded.
- Reset mid-stream drops buffered pixels; the next accepted code is column 0.

## Timing

- Reset values: `rgb_valid_out`=0, `rgb_out`=0, `eol_out`=0, `code_ready_out`=1 from the first cycle after reset.
- Latency: a code accepted at edge N into an empty buffer is visible on `rgb_out` with `rgb_valid_out`=1 in the cycle after edge N.
- Throughput is 1 pixel/clock while `rgb_ready_in` stays high.
- After downstream stalls 2 cycles, `code_ready_out` drops in the cycle after the second fill edge. It rises again in the cycle after the first pop.
- A level write at edge N affects codes accepted at edge N+1 onward.

## Test plan

1. **Basic mapping**
   - Stimulus: reset, then codes 3'b000, 3'b101, 3'b111 back-to-back with `rgb_ready_in`=1.
   - Required: `rgb_out` = 0x000000, 0xFF00FF, 0xFFFFFF on consecutive cycles, starting 1 cycle after the first accept.
2. **Level programming**
   - Stimulus: write green low=50, high=200, then code 3'b010 followed by 3'b000.
   - Required: green field 200 then 50; red and blue 0.
   - Stimulus: write with `level_chan_in`=3.
   - Required: no change to any level.
3. **Write/accept collision**
   - Stimulus: red high=100 written at the same edge as accepting 3'b001, then 3'b001 again.
   - Required: red 255 then 100.
4. **Backpressure**
   - Stimulus: `rgb_ready_in`=0 while codes 1, 2, 4 are offered.
   - Required: only 1 and 2 are accepted, `code_ready_out`=0, and `rgb_out` holds 0x0000FF stable.
   - Stimulus: release ready.
   - Required: outputs 0x0000FF, 0x00FF00, 0xFF0000 with no loss or duplication.
5. **End of line**
   - Stimulus: `LINE_WIDTH`=4, 9 accepts.
   - Required: `eol_out`=1 only on pixels 4 and 8 (1-based); the 9th pixel starts a new line.
6. **Reset mid-operation**
   - Stimulus: 2 pixels buffered, a custom level loaded, column 2, then `rst_in` pulsed.
   - Required: `rgb_valid_out`=0 and levels back to default; after 3 more accepts at `LINE_WIDTH`=4, none carries eol.

Source files
------------

// File: rtl/rgb_expand.sv
// rgb_expand
//   Expands the 3-bit thresholded colour code stream (bit0 red, bit1 green,
//   bit2 blue) back into full RGB pixels. Each code bit selects the channel's
//   programmable high or low level. Pixels leave through a 2-entry output
//   buffer, tagged with an end-of-line flag on column LINE_WIDTH-1.
//
//   Ports
//     clk_in, rst_in          clock, synchronous active-high reset
//     code_valid_in/code_in   input code stream (valid/ready)
//     code_ready_out          space available in the output buffer
//     level_wr_in             level register write strobe
//     level_chan_in           0 red, 1 green, 2 blue, 3 no write
//     level_hi_in             1 = high level, 0 = low level
//     level_data_in           level value
//     rgb_valid_out/rgb_ready_in  output pixel handshake
//     rgb_out                 {blue, green, red}
//     eol_out                 head pixel is the last of its line
module rgb_expand #(
   parameter int COLOUR_DEPTH = 8,
   parameter int LINE_WIDTH   = 640,
   parameter int LOW_DEFAULT  = 0,
   parameter int HIGH_DEFAULT = 2**COLOUR_DEPTH-1
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      code_valid_in,
   input  logic [2:0]                code_in,
   output logic                      code_ready_out,
   input  logic                      level_wr_in,
   input  logic [1:0]                level_chan_in,
   input  logic                      level_hi_in,
   input  logic [COLOUR_DEPTH-1:0]   level_data_in,
   output logic                      rgb_valid_out,
   input  logic                      rgb_ready_in,
   output logic [3*COLOUR_DEPTH-1:0] rgb_out,
   output logic                      eol_out
);

   localparam int CD = COLOUR_DEPTH;
   localparam int PW = 3 * CD;
   localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam logic [CD-1:0] LO_RST   = CD'(LOW_DEFAULT);
   localparam logic [CD-1:0] HI_RST   = CD'(HIGH_DEFAULT);
   localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);

   // Levels are packed per channel in the same layout as rgb_out.
   logic [PW-1:0] lo_q, lo_d, hi_q, hi_d;
   logic [CW-1:0] col_q, col_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic          head_eol_q, head_eol_d, tail_eol_q, tail_eol_d;

   logic          accept, pop;
   logic [PW-1:0] new_pix;
   logic          new_eol;

   function automatic logic [PW-1:0] expand(input logic [2:0]    code,
                                            input logic [PW-1:0] lo,
                                            input logic [PW-1:0] hi);
      logic [PW-1:0] res;
      res = '0;
      for (int c = 0; c < 3; c++) begin
         res[c*CD +: CD] = code[c] ? hi[c*CD +: CD] : lo[c*CD +: CD];
      end
      return res;
   endfunction

   // Ready depends only on registered occupancy, never on rgb_ready_in.
   assign code_ready_out = (cnt_q != 2'd2);
   assign rgb_valid_out  = (cnt_q != 2'd0);
   assign rgb_out        = head_q;
   assign eol_out        = head_eol_q;

   assign accept  = code_valid_in && code_ready_out;
   assign pop     = rgb_valid_out && rgb_ready_in;
   assign new_pix = expand(code_in, lo_q, hi_q);
   assign new_eol = (col_q == COL_LAST);

   always_comb begin
      lo_d       = lo_q;
      hi_d       = hi_q;
      col_d      = col_q;
      cnt_d      = cnt_q;
      head_d     = head_q;
      head_eol_d = head_eol_q;
      tail_d     = tail_q;
      tail_eol_d = tail_eol_q;

      if (accept) begin
         col_d = new_eol ? '0 : col_q + CW'(1);
      end

      case (cnt_q)
         2'd0: begin
            if (accept) begin
               head_d     = new_pix;
               head_eol_d = new_eol;
               cnt_d      = 2'd1;
            end
         end
         2'd1: begin
            if (accept && pop) begin
               head_d     = new_pix;
               head_eol_d = new_eol;
            end else if (accept) begin
               tail_d     = new_pix;
               tail_eol_d = new_eol;
               cnt_d      = 2'd2;
            end else if (pop) begin
               cnt_d = 2'd0;
            end
         end
         default: begin
            // Full: no accept is possible, a pop promotes the second entry.
            if (pop) begin
               head_d     = tail_q;
               head_eol_d = tail_eol_q;
               cnt_d      = 2'd1;
            end
         end
      endcase

      // Channel 3 matches no loop index, so it writes nothing.
      if (level_wr_in) begin
         for (int c = 0; c < 3; c++) begin
            if (level_chan_in == 2'(c)) begin
               if (level_hi_in) hi_d[c*CD +: CD] = level_data_in;
               else             lo_d[c*CD +: CD] = level_data_in;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         lo_q       <= {3{LO_RST}};
         hi_q       <= {3{HI_RST}};
         col_q      <= '0;
         cnt_q      <= 2'd0;
         head_q     <= '0;
         head_eol_q <= 1'b0;
      end else begin
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         col_q      <= col_d;
         cnt_q      <= cnt_d;
         head_q     <= head_d;
         head_eol_q <= head_eol_d;
      end
   end

   // Second entry is only read when occupancy says it is valid.
   always_ff @(posedge clk_in) begin
      tail_q     <= tail_d;
      tail_eol_q <= tail_eol_d;
   end

endmodule

// File: tb/tb_rgb_expand.sv
module tb_rgb_expand;

   localparam int CD = 8;
   localparam int LW = 4;

   logic            clk_in = 1'b0;
   logic            rst_in = 1'b0;
   logic            code_valid_in = 1'b0;
   logic [2:0]      code_in = 3'd0;
   logic            code_ready_out;
   logic            level_wr_in = 1'b0;
   logic [1:0]      level_chan_in = 2'd0;
   logic            level_hi_in = 1'b0;
   logic [CD-1:0]   level_data_in = '0;
   logic            rgb_valid_out;
   logic            rgb_ready_in = 1'b1;
   logic [3*CD-1:0] rgb_out;
   logic            eol_out;

   rgb_expand #(.COLOUR_DEPTH(CD), .LINE_WIDTH(LW)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .code_valid_in(code_valid_in), .code_in(code_in), .code_ready_out(code_ready_out),
      .level_wr_in(level_wr_in), .level_chan_in(level_chan_in),
      .level_hi_in(level_hi_in), .level_data_in(level_data_in),
      .rgb_valid_out(rgb_valid_out), .rgb_ready_in(rgb_ready_in),
      .rgb_out(rgb_out), .eol_out(eol_out)
   );

   always #5 clk_in = ~clk_in;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: levels as integers, pixels as a queue of {eol, rgb}.
   int lo_m[3];
   int hi_m[3];
   int col_m;
   logic [24:0] q_m[$];
   int n_acc;     // accepts seen by the model since last cleared
   int n_eol_pop; // popped pixels carrying eol

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] model_pix(input logic [2:0] code);
      int v;
      v = 0;
      for (int c = 0; c < 3; c++) begin
         v = v + ((code[c] ? hi_m[c] : lo_m[c]) << (8 * c));
      end
      return 24'(v);
   endfunction

   task automatic model_reset();
      q_m.delete();
      col_m = 0;
      for (int c = 0; c < 3; c++) begin
         lo_m[c] = 0;
         hi_m[c] = 255;
      end
   endtask

   // One clock: check outputs at the falling edge, then advance the model
   // with the inputs that the rising edge samples.
   task automatic cyc();
      bit acc, pp;
      @(negedge clk_in);
      chk("ready", code_ready_out, (q_m.size() != 2));
      chk("valid", rgb_valid_out, (q_m.size() != 0));
      if (q_m.size() != 0) begin
         chk("rgb", rgb_out, q_m[0][23:0]);
         chk("eol", eol_out, q_m[0][24]);
      end
      acc = code_valid_in && (q_m.size() != 2);
      pp  = rgb_ready_in && (q_m.size() != 0);
      @(posedge clk_in);
      if (rst_in) begin
         model_reset();
      end else begin
         if (pp) begin
            if (q_m[0][24]) n_eol_pop++;
            void'(q_m.pop_front());
         end
         if (acc) begin
            q_m.push_back({(col_m == LW - 1), model_pix(code_in)});
            col_m = (col_m + 1) % LW;
            n_acc++;
         end
         if (level_wr_in && level_chan_in != 2'd3) begin
            if (level_hi_in) hi_m[level_chan_in] = int'(level_data_in);
            else             lo_m[level_chan_in] = int'(level_data_in);
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      cyc();
      rst_in = 1'b0;
      @(negedge clk_in);
      chk("rst_valid", rgb_valid_out, 1'b0);
      chk("rst_ready", code_ready_out, 1'b1);
      chk("rst_rgb", rgb_out, 24'h0);
      chk("rst_eol", eol_out, 1'b0);
      @(posedge clk_in);
      #1;
   endtask

   task automatic send(input logic [2:0] c);
      code_valid_in = 1'b1;
      code_in = c;
      cyc();
      code_valid_in = 1'b0;
   endtask

   task automatic wr_level(input logic [1:0] ch, input logic hi, input logic [7:0] d);
      level_wr_in = 1'b1;
      level_chan_in = ch;
      level_hi_in = hi;
      level_data_in = d;
      cyc();
      level_wr_in = 1'b0;
   endtask

   task automatic drain();
      rgb_ready_in = 1'b1;
      code_valid_in = 1'b0;
      repeat (4) cyc();
   endtask

   initial begin
      model_reset();
      n_acc = 0;
      n_eol_pop = 0;
      @(posedge clk_in);
      #1;
      do_reset();

      // Basic mapping, back-to-back.
      rgb_ready_in = 1'b1;
      send(3'b000); send(3'b101); send(3'b111);
      drain();

      // Level programming, then an ignored channel-3 write.
      wr_level(2'd1, 1'b0, 8'd50);
      wr_level(2'd1, 1'b1, 8'd200);
      send(3'b010); send(3'b000);
      wr_level(2'd3, 1'b1, 8'd77);
      wr_level(2'd3, 1'b0, 8'd77);
      send(3'b111); send(3'b000);
      drain();

      // Write and accept on the same edge use the old level.
      level_wr_in = 1'b1; level_chan_in = 2'd0; level_hi_in = 1'b1; level_data_in = 8'd100;
      send(3'b001);
      level_wr_in = 1'b0;
      send(3'b001);
      drain();

      // Backpressure: only two codes fit.
      rgb_ready_in = 1'b0;
      n_acc = 0;
      code_valid_in = 1'b1;
      code_in = 3'd1; cyc();
      code_in = 3'd2; cyc();
      code_in = 3'd4; repeat (3) cyc();
      chk("bp_accepts", n_acc, 2);
      code_valid_in = 1'b0;
      drain();

      // End of line after a fresh reset: 9 accepts, two eol pixels.
      do_reset();
      n_eol_pop = 0;
      repeat (9) send(3'($urandom_range(0, 7)));
      drain();
      chk("eol_count", n_eol_pop, 2);

      // Reset mid-operation with two buffered pixels and a custom level.
      do_reset();
      rgb_ready_in = 1'b0;
      wr_level(2'd0, 1'b0, 8'd9);
      send(3'b010); send(3'b110);
      do_reset();
      n_eol_pop = 0;
      rgb_ready_in = 1'b1;
      send(3'b000); send(3'b111); send(3'b000);
      drain();
      chk("rst_eol_count", n_eol_pop, 0);

      // Randomized traffic with occasional level writes and resets.
      for (int i = 0; i < 400; i++) begin
         code_valid_in = ($urandom_range(0, 3) != 0);
         code_in       = 3'($urandom_range(0, 7));
         rgb_ready_in  = ($urandom_range(0, 2) != 0);
         level_wr_in   = ($urandom_range(0, 9) == 0);
         level_chan_in = 2'($urandom_range(0, 3));
         level_hi_in   = 1'($urandom_range(0, 1));
         level_data_in = 8'($urandom_range(0, 255));
         rst_in        = ($urandom_range(0, 99) == 0);
         cyc();
      end
      rst_in = 1'b0;
      level_wr_in = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
